buf_exchange_hub: RTL and testbench

- Inter-core exchange point for the multicore build.
- Sits directly downstream of each core's buffer register: it consumes every core's buf_val_1/buf_val_2/buf_flag.
- Feeds every core back through buf_val_1_select/buf_val_2_select and the all_buf_flags barrier signal.
- Double-buffered: a staging table collects one round of values; a committed table serves reads while the next round is collected.

---
 rtl/buf_exchange_hub.sv | 129 ++++++++++++
 tb/tb_buf_exchange_hub.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/buf_exchange_hub.sv
// Double-buffered inter-core exchange point: collects one value pair per core per round,
// commits the round at the barrier and serves zero-latency reads from the committed table.
module buf_exchange_hub #(
  parameter int CORES   = 4,
  parameter int ADDR_W  = 3,
  parameter int EPOCH_W = 8
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic [32*CORES-1:0]   buf_val_1,
  input  logic [32*CORES-1:0]   buf_val_2,
  input  logic [CORES-1:0]      buf_flag,
  input  logic [ADDR_W*CORES-1:0] buf_val_1_addr,
  input  logic [ADDR_W*CORES-1:0] buf_val_2_addr,
  output logic [32*CORES-1:0]   buf_val_1_select,
  output logic [32*CORES-1:0]   buf_val_2_select,
  output logic                  all_buf_flags,
  output logic [EPOCH_W-1:0]    epoch,
  output logic [CORES-1:0]      captured
);

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    RELEASE = 2'd1,
    DRAIN   = 2'd2
  } state_t;

  state_t             state_r;
  logic [CORES-1:0]   captured_r;
  logic               all_buf_flags_r;
  logic [EPOCH_W-1:0] epoch_r;
  logic [31:0]        staging_1_r   [CORES];
  logic [31:0]        staging_2_r   [CORES];
  logic [31:0]        committed_1_r [CORES];
  logic [31:0]        committed_2_r [CORES];

  logic [CORES-1:0]   new_cap_s;
  logic [CORES-1:0]   cap_next_s;
  logic               all_cap_s;
  logic [32*CORES-1:0] sel_1_s;
  logic [32*CORES-1:0] sel_2_s;

  // Capture candidates this cycle: flagged cores not yet captured, only while collecting.
  always_comb begin
    new_cap_s = {CORES{1'b0}};
    if (state_r == COLLECT) begin
      new_cap_s = buf_flag & ~captured_r;
    end else begin
      new_cap_s = {CORES{1'b0}};
    end
    cap_next_s = captured_r | new_cap_s;
    all_cap_s  = (state_r == COLLECT) && (&cap_next_s);
  end

  // Barrier FSM together with the staging/committed tables and round counter.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_r         <= COLLECT;
      captured_r      <= {CORES{1'b0}};
      all_buf_flags_r <= 1'b0;
      epoch_r         <= {EPOCH_W{1'b0}};
      for (int i = 0; i < CORES; i++) begin
        staging_1_r[i]   <= 32'h0;
        staging_2_r[i]   <= 32'h0;
        committed_1_r[i] <= 32'h0;
        committed_2_r[i] <= 32'h0;
      end
    end else begin
      case (state_r)
        COLLECT: begin
          for (int i = 0; i < CORES; i++) begin
            if (new_cap_s[i]) begin
              staging_1_r[i] <= buf_val_1[32*i +: 32];
              staging_2_r[i] <= buf_val_2[32*i +: 32];
            end
          end
          captured_r <= cap_next_s;
          // The last capture bypasses staging so the commit includes this cycle's values.
          if (all_cap_s) begin
            for (int i = 0; i < CORES; i++) begin
              committed_1_r[i] <= new_cap_s[i] ? buf_val_1[32*i +: 32] : staging_1_r[i];
              committed_2_r[i] <= new_cap_s[i] ? buf_val_2[32*i +: 32] : staging_2_r[i];
            end
            epoch_r         <= epoch_r + {{(EPOCH_W-1){1'b0}}, 1'b1};
            state_r         <= RELEASE;
            all_buf_flags_r <= 1'b1;
          end
        end
        RELEASE: begin
          if (buf_flag == {CORES{1'b0}}) begin
            state_r         <= DRAIN;
            all_buf_flags_r <= 1'b0;
          end
        end
        DRAIN: begin
          captured_r      <= {CORES{1'b0}};
          all_buf_flags_r <= 1'b0;
          state_r         <= COLLECT;
        end
        default: begin
          captured_r      <= {CORES{1'b0}};
          all_buf_flags_r <= 1'b0;
          state_r         <= COLLECT;
        end
      endcase
    end
  end

  // Read muxes: an index with no matching core contributes nothing, yielding zero.
  always_comb begin
    sel_1_s = {(32*CORES){1'b0}};
    sel_2_s = {(32*CORES){1'b0}};
    for (int c = 0; c < CORES; c++) begin
      for (int j = 0; j < CORES; j++) begin
        sel_1_s[32*c +: 32] = sel_1_s[32*c +: 32] |
          ((32'(buf_val_1_addr[ADDR_W*c +: ADDR_W]) == 32'(j)) ? committed_1_r[j] : 32'h0);
        sel_2_s[32*c +: 32] = sel_2_s[32*c +: 32] |
          ((32'(buf_val_2_addr[ADDR_W*c +: ADDR_W]) == 32'(j)) ? committed_2_r[j] : 32'h0);
      end
    end
  end

  assign buf_val_1_select = sel_1_s;
  assign buf_val_2_select = sel_2_s;
  assign all_buf_flags    = all_buf_flags_r;
  assign epoch            = epoch_r;
  assign captured         = captured_r;

endmodule

// File: tb/tb_buf_exchange_hub.sv
// Directed, table-driven bench for buf_exchange_hub (CORES=4) with hand-written reset sequence.
module tb_buf_exchange_hub;

  logic         Clk;
  logic         Reset;
  logic [127:0] buf_val_1;
  logic [127:0] buf_val_2;
  logic [3:0]   buf_flag;
  logic [11:0]  buf_val_1_addr;
  logic [11:0]  buf_val_2_addr;
  logic [127:0] buf_val_1_select;
  logic [127:0] buf_val_2_select;
  logic         all_buf_flags;
  logic [7:0]   epoch;
  logic [3:0]   captured;

  int n_checks;
  int n_fail;

  buf_exchange_hub #(.CORES(4), .ADDR_W(3), .EPOCH_W(8)) dut (
    .Clk              (Clk),
    .Reset            (Reset),
    .buf_val_1        (buf_val_1),
    .buf_val_2        (buf_val_2),
    .buf_flag         (buf_flag),
    .buf_val_1_addr   (buf_val_1_addr),
    .buf_val_2_addr   (buf_val_2_addr),
    .buf_val_1_select (buf_val_1_select),
    .buf_val_2_select (buf_val_2_select),
    .all_buf_flags    (all_buf_flags),
    .epoch            (epoch),
    .captured         (captured)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic [3:0]   flag;
    logic [127:0] v1;
    logic [127:0] v2;
    logic         abf;
    logic [7:0]   ep;
    logic [3:0]   cap;
    logic [127:0] s1;
    logic [127:0] s2;
  } vec_t;

  vec_t vecs[14];

  function automatic logic [127:0] p4(input logic [31:0] a0, input logic [31:0] a1,
                                      input logic [31:0] a2, input logic [31:0] a3);
    return {a3, a2, a1, a0};
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic abf, input logic [7:0] ep,
                         input logic [3:0] cap, input logic [127:0] s1, input logic [127:0] s2);
    chk({tag, " all_buf_flags"}, 128'(all_buf_flags), 128'(abf));
    chk({tag, " epoch"}, 128'(epoch), 128'(ep));
    chk({tag, " captured"}, 128'(captured), 128'(cap));
    chk({tag, " sel1"}, buf_val_1_select, s1);
    chk({tag, " sel2"}, buf_val_2_select, s2);
  endtask

  initial begin
    logic [127:0] a1, a2, b1, b1x, b2, c1, c2;
    logic [127:0] r1s1, r1s2, r2s1, r2s2;
    n_checks = 0;
    n_fail   = 0;

    // Read addresses: core0 a1=0, core1 a1=1, core2 a1=3, core3 a1=5 (out of range);
    // core0 a2=1, core1 a2=2, core2 a2=3, core3 a2=0.
    buf_val_1_addr = {3'd5, 3'd3, 3'd1, 3'd0};
    buf_val_2_addr = {3'd0, 3'd3, 3'd2, 3'd1};

    a1   = p4(32'd10, 32'd11, 32'd12, 32'd13);
    a2   = p4(32'd20, 32'd21, 32'd22, 32'd23);
    b1   = p4(32'd5,  32'd31, 32'd32, 32'd33);
    b1x  = p4(32'd9,  32'd31, 32'd32, 32'd33);
    b2   = p4(32'd40, 32'd41, 32'd42, 32'd43);
    c1   = p4(32'd50, 32'd51, 32'd52, 32'd53);
    c2   = p4(32'd60, 32'd61, 32'd62, 32'd63);
    r1s1 = p4(32'd10, 32'd11, 32'd13, 32'd0);
    r1s2 = p4(32'd21, 32'd22, 32'd23, 32'd20);
    r2s1 = p4(32'd5,  32'd31, 32'd33, 32'd0);
    r2s2 = p4(32'd41, 32'd42, 32'd43, 32'd40);

    vecs[0]  = '{4'b1111, a1,  a2, 1'b1, 8'd1, 4'b1111, r1s1, r1s2};
    vecs[1]  = '{4'b0000, a1,  a2, 1'b0, 8'd1, 4'b1111, r1s1, r1s2};
    vecs[2]  = '{4'b0000, a1,  a2, 1'b0, 8'd1, 4'b0000, r1s1, r1s2};
    vecs[3]  = '{4'b0001, b1,  b2, 1'b0, 8'd1, 4'b0001, r1s1, r1s2};
    vecs[4]  = '{4'b0011, b1x, b2, 1'b0, 8'd1, 4'b0011, r1s1, r1s2};
    vecs[5]  = '{4'b0011, b1x, b2, 1'b0, 8'd1, 4'b0011, r1s1, r1s2};
    vecs[6]  = '{4'b0111, b1x, b2, 1'b0, 8'd1, 4'b0111, r1s1, r1s2};
    vecs[7]  = '{4'b0111, b1x, b2, 1'b0, 8'd1, 4'b0111, r1s1, r1s2};
    vecs[8]  = '{4'b1111, b1x, b2, 1'b1, 8'd2, 4'b1111, r2s1, r2s2};
    vecs[9]  = '{4'b1010, b1x, b2, 1'b1, 8'd2, 4'b1111, r2s1, r2s2};
    vecs[10] = '{4'b1000, b1x, b2, 1'b1, 8'd2, 4'b1111, r2s1, r2s2};
    vecs[11] = '{4'b0000, b1x, b2, 1'b0, 8'd2, 4'b1111, r2s1, r2s2};
    vecs[12] = '{4'b0100, c1,  c2, 1'b0, 8'd2, 4'b0000, r2s1, r2s2};
    vecs[13] = '{4'b0100, c1,  c2, 1'b0, 8'd2, 4'b0100, r2s1, r2s2};

    // Reset state
    Reset     = 1'b0;
    buf_flag  = 4'b0000;
    buf_val_1 = 128'h0;
    buf_val_2 = 128'h0;
    step();
    step();
    chk_all("reset", 1'b0, 8'd0, 4'b0000, 128'h0, 128'h0);
    @(negedge Clk);
    Reset = 1'b1;

    for (int i = 0; i < 14; i++) begin
      buf_flag  = vecs[i].flag;
      buf_val_1 = vecs[i].v1;
      buf_val_2 = vecs[i].v2;
      step();
      chk_all($sformatf("v%0d", i), vecs[i].abf, vecs[i].ep, vecs[i].cap, vecs[i].s1, vecs[i].s2);
    end

    // Mid-COLLECT asynchronous reset with captured=0101
    buf_flag = 4'b0101;
    step();
    chk_all("pre_rst", 1'b0, 8'd2, 4'b0101, r2s1, r2s2);
    #2;
    Reset = 1'b0;
    #1;
    chk_all("async_rst", 1'b0, 8'd0, 4'b0000, 128'h0, 128'h0);
    @(negedge Clk);
    Reset    = 1'b1;
    buf_flag = 4'b0000;
    step();
    chk_all("post_rst_idle", 1'b0, 8'd0, 4'b0000, 128'h0, 128'h0);
    buf_flag = 4'b0111;
    step();
    chk_all("post_rst_partial", 1'b0, 8'd0, 4'b0111, 128'h0, 128'h0);
    buf_flag = 4'b1111;
    step();
    chk_all("post_rst_commit", 1'b1, 8'd1, 4'b1111,
            p4(32'd50, 32'd51, 32'd53, 32'd0), p4(32'd61, 32'd62, 32'd63, 32'd60));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
